// File: rtl/cp0_exception_unit_if.sv
// rtl/cp0_exception_unit_if.sv - pipeline <-> CP0 signal bundle
interface cp0_if;
    logic        id_valid;
    logic        stall;
    logic        mtc_en;
    logic        mfc_en;
    logic        eret_en;
    logic [4:0]  cp0_addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        undef_exc;
    logic [31:0] id_pc;
    logic        mem_oor_exc;
    logic        mem_is_store;
    logic [31:0] exe_pc;
    logic [31:0] bad_addr;
    logic [4:0]  ext_int;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        flush_exe;
    logic        exl;

    // Pipeline side: drives decode/execute information, receives redirect
    modport master (
        output id_valid, stall, mtc_en, mfc_en, eret_en, cp0_addr, wdata,
               undef_exc, id_pc, mem_oor_exc, mem_is_store, exe_pc,
               bad_addr, ext_int,
        input  rdata, redirect, redirect_pc, flush_exe, exl
    );

    // CP0 side
    modport slave (
        input  id_valid, stall, mtc_en, mfc_en, eret_en, cp0_addr, wdata,
               undef_exc, id_pc, mem_oor_exc, mem_is_store, exe_pc,
               bad_addr, ext_int,
        output rdata, redirect, redirect_pc, flush_exe, exl
    );
endinterface

// File: rtl/cp0_exception_unit.sv
// rtl/cp0_exception_unit.sv - CP0 registers, exception/interrupt arbitration, PC redirect
module cp0_exception_unit #(
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0008,
    parameter bit          COUNT_EN   = 1'b1
) (
    input logic   clk,
    input logic   rst,
    cp0_if.slave  bus
);
    localparam logic [4:0] A_BADVADDR = 5'd8;
    localparam logic [4:0] A_COUNT    = 5'd9;
    localparam logic [4:0] A_COMPARE  = 5'd11;
    localparam logic [4:0] A_STATUS   = 5'd12;
    localparam logic [4:0] A_CAUSE    = 5'd13;
    localparam logic [4:0] A_EPC      = 5'd14;

    logic        ie_q, ie_d;
    logic        exl_q, exl_d;
    logic [5:0]  im_q, im_d;
    logic [4:0]  exc_code_q, exc_code_d;
    logic [5:0]  ip_q, ip_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] badvaddr_q, badvaddr_d;
    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic [4:0]  sync1_q, sync1_d;
    logic [4:0]  sync2_q, sync2_d;
    logic [4:0]  sync3_q, sync3_d;

    logic        id_ok;
    logic        take_mem;
    logic        take_ri;
    logic        take_int;
    logic        take_exc;
    logic        eret_fire;
    logic        mtc_fire;
    logic [31:0] status_rd;
    logic [31:0] cause_rd;

    // Register read views and prioritised event arbitration
    always_comb begin
        status_rd = {16'h0, im_q, 8'h0, exl_q, ie_q};
        cause_rd  = {16'h0, ip_q, 3'b000, exc_code_q, 2'b00};

        id_ok     = bus.id_valid & ~bus.stall;
        take_mem  = bus.mem_oor_exc;
        take_ri   = bus.undef_exc & id_ok;
        take_int  = (|(ip_q & im_q)) & ie_q & ~exl_q & id_ok;
        take_exc  = take_mem | take_ri | take_int;
        eret_fire = bus.eret_en & id_ok & ~take_exc;
        mtc_fire  = bus.mtc_en & id_ok & ~take_exc;

        bus.redirect    = take_exc | eret_fire;
        bus.redirect_pc = take_exc ? EXC_VECTOR : epc_q;
        bus.flush_exe   = take_mem;
        bus.exl         = exl_q;

        case (bus.cp0_addr)
            A_BADVADDR: bus.rdata = badvaddr_q;
            A_COUNT:    bus.rdata = count_q;
            A_COMPARE:  bus.rdata = compare_q;
            A_STATUS:   bus.rdata = status_rd;
            A_CAUSE:    bus.rdata = cause_rd;
            A_EPC:      bus.rdata = epc_q;
            default:    bus.rdata = 32'h0;
        endcase
    end

    // Next-state for registers, interrupt pending bits and timer
    always_comb begin
        ie_d       = ie_q;
        exl_d      = exl_q;
        im_d       = im_q;
        exc_code_d = exc_code_q;
        ip_d       = ip_q;
        epc_d      = epc_q;
        badvaddr_d = badvaddr_q;
        compare_d  = compare_q;
        count_d    = COUNT_EN ? count_q + 32'd1 : count_q;

        sync1_d = bus.ext_int;
        sync2_d = sync1_q;
        sync3_d = sync2_q;

        // Software writes go first so hardware set events below win over clears
        if (mtc_fire) begin
            case (bus.cp0_addr)
                A_COUNT:   count_d = bus.wdata;
                A_COMPARE: compare_d = bus.wdata;
                A_STATUS: begin
                    ie_d  = bus.wdata[0];
                    exl_d = bus.wdata[1];
                    im_d  = bus.wdata[15:10];
                end
                A_CAUSE:   ip_d[4:0] = bus.wdata[14:10];
                A_EPC:     epc_d = bus.wdata;
                default:   ;
            endcase
        end

        ip_d[4:0] = ip_d[4:0] | (sync2_q & ~sync3_q);

        // A Compare write re-arms the timer, so it takes precedence over a match
        if (mtc_fire && bus.cp0_addr == A_COMPARE) begin
            ip_d[5] = 1'b0;
        end else if (count_q == compare_q && compare_q != 32'h0) begin
            ip_d[5] = 1'b1;
        end

        if (eret_fire) begin
            exl_d = 1'b0;
        end

        if (take_exc) begin
            exl_d = 1'b1;
            if (take_mem) begin
                exc_code_d = bus.mem_is_store ? 5'd5 : 5'd4;
                badvaddr_d = bus.bad_addr;
            end else if (take_ri) begin
                exc_code_d = 5'd10;
            end else begin
                exc_code_d = 5'd0;
            end
            // A nested exception keeps the EPC of the original one
            if (!exl_q) begin
                epc_d = take_mem ? bus.exe_pc : bus.id_pc;
            end
        end
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ie_q       <= 1'b0;
            exl_q      <= 1'b0;
            im_q       <= 6'h0;
            exc_code_q <= 5'h0;
            ip_q       <= 6'h0;
            epc_q      <= 32'h0;
            badvaddr_q <= 32'h0;
            count_q    <= 32'h0;
            compare_q  <= 32'h0;
            sync1_q    <= 5'h0;
            sync2_q    <= 5'h0;
            sync3_q    <= 5'h0;
        end else begin
            ie_q       <= ie_d;
            exl_q      <= exl_d;
            im_q       <= im_d;
            exc_code_q <= exc_code_d;
            ip_q       <= ip_d;
            epc_q      <= epc_d;
            badvaddr_q <= badvaddr_d;
            count_q    <= count_d;
            compare_q  <= compare_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            sync3_q    <= sync3_d;
        end
    end
endmodule

// File: tb/tb_cp0_exception_unit.sv
// tb/tb_cp0_exception_unit.sv - scoreboard bench for cp0_exception_unit
module tb_cp0_exception_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;

    cp0_if bus();

    cp0_exception_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [32:0] val;
    } exp_t;

    exp_t redir_q[$];
    exp_t read_q[$];
    exp_t mon_e;
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%h required=%h", name, act, exp);
    endtask

    // Monitor: consumes an expectation whenever the DUT redirects or an MFC0 is presented
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.redirect) begin
                if (redir_q.size() == 0) begin
                    n_total++;
                    $display("FAIL spurious_redirect: actual pc=%h flush=%b required no redirect",
                             bus.redirect_pc, bus.flush_exe);
                end else begin
                    mon_e = redir_q.pop_front();
                    check(mon_e.name, {bus.flush_exe, bus.redirect_pc}, mon_e.val);
                end
            end
            if (bus.mfc_en && bus.id_valid) begin
                if (read_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_read: actual=%h required no read", bus.rdata);
                end else begin
                    mon_e = read_q.pop_front();
                    check(mon_e.name, {1'b0, bus.rdata}, mon_e.val);
                end
            end
        end
    end

    task automatic push_redir(input string n, input logic [31:0] pc, input logic f);
        exp_t e;
        e.name = n;
        e.val  = {f, pc};
        redir_q.push_back(e);
    endtask

    task automatic push_read(input string n, input logic [31:0] v);
        exp_t e;
        e.name = n;
        e.val  = {1'b0, v};
        read_q.push_back(e);
    endtask

    task automatic idle();
        bus.id_valid     = 1'b0;
        bus.stall        = 1'b0;
        bus.mtc_en       = 1'b0;
        bus.mfc_en       = 1'b0;
        bus.eret_en      = 1'b0;
        bus.cp0_addr     = 5'd0;
        bus.wdata        = 32'h0;
        bus.undef_exc    = 1'b0;
        bus.id_pc        = 32'h0;
        bus.mem_oor_exc  = 1'b0;
        bus.mem_is_store = 1'b0;
        bus.exe_pc       = 32'h0;
        bus.bad_addr     = 32'h0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic do_mtc(input logic [4:0] a, input logic [31:0] d, input logic [31:0] pc);
        bus.id_valid = 1'b1;
        bus.mtc_en   = 1'b1;
        bus.cp0_addr = a;
        bus.wdata    = d;
        bus.id_pc    = pc;
        step();
    endtask

    task automatic do_mfc(input string n, input logic [4:0] a, input logic [31:0] exp);
        push_read(n, exp);
        bus.id_valid = 1'b1;
        bus.mfc_en   = 1'b1;
        bus.cp0_addr = a;
        bus.id_pc    = 32'h300;
        step();
    endtask

    task automatic do_eret(input string n, input logic [31:0] epc);
        push_redir(n, epc, 1'b0);
        bus.id_valid = 1'b1;
        bus.eret_en  = 1'b1;
        step();
    endtask

    task automatic do_undef(input string n, input logic [31:0] pc);
        push_redir(n, 32'h8, 1'b0);
        bus.id_valid  = 1'b1;
        bus.undef_exc = 1'b1;
        bus.id_pc     = pc;
        step();
    endtask

    task automatic do_mem(input string n, input logic st, input logic [31:0] pc, input logic [31:0] ba);
        push_redir(n, 32'h8, 1'b1);
        bus.id_valid     = 1'b1;
        bus.stall        = 1'b1;
        bus.undef_exc    = 1'b1;
        bus.mem_oor_exc  = 1'b1;
        bus.mem_is_store = st;
        bus.exe_pc       = pc;
        bus.bad_addr     = ba;
        step();
    endtask

    task automatic pulse_ext0();
        bus.ext_int = 5'b00001;
        step();
        bus.ext_int = 5'b00000;
        repeat (4) step();
    endtask

    initial begin
        idle();
        bus.ext_int = 5'h0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_redirect", {32'h0, bus.redirect}, 33'h0);
        check("rst_flush", {32'h0, bus.flush_exe}, 33'h0);
        check("rst_exl", {32'h0, bus.exl}, 33'h0);
        bus.cp0_addr = 5'd12;
        #1 check("rst_status", {1'b0, bus.rdata}, 33'h0);
        bus.cp0_addr = 5'd14;
        #1 check("rst_epc", {1'b0, bus.rdata}, 33'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle();

        // Timer: Compare=5 straight out of reset
        do_mtc(5'd11, 32'd5, 32'h0);
        repeat (8) step();
        do_mfc("timer_ip15", 5'd13, 32'h0000_8000);
        do_mtc(5'd12, 32'h0000_0401, 32'h0);
        do_mfc("status_write", 5'd12, 32'h0000_0401);
        do_mtc(5'd11, 32'd0, 32'h0);
        do_mfc("compare_clear_ip15", 5'd13, 32'h0);
        do_mtc(5'd9, 32'd100, 32'h0);
        do_mfc("count_write", 5'd9, 32'd100);
        do_mfc("unmapped_read", 5'd5, 32'h0);
        do_mtc(5'd8, 32'hDEAD_BEEF, 32'h0);
        do_mfc("badvaddr_ro", 5'd8, 32'h0);

        // External interrupt on line 0 taken by the next valid ID instruction
        pulse_ext0();
        push_redir("int_redirect", 32'h8, 1'b0);
        push_read("int_cause", 32'h0000_0400);
        bus.id_valid = 1'b1;
        bus.mfc_en   = 1'b1;
        bus.cp0_addr = 5'd13;
        bus.id_pc    = 32'h100;
        step();
        check("int_exl", {32'h0, bus.exl}, 33'h1);
        do_mfc("int_epc", 5'd14, 32'h100);
        do_mfc("int_status", 5'd12, 32'h0000_0403);

        // Nested undefined instruction keeps EPC
        do_undef("nested_redirect", 32'h60);
        do_mfc("nested_epc", 5'd14, 32'h100);
        do_mfc("nested_cause", 5'd13, 32'h0000_0428);
        do_mtc(5'd13, 32'h0, 32'h0);
        do_eret("eret_after_int", 32'h100);
        check("eret_exl", {32'h0, bus.exl}, 33'h0);
        do_mfc("status_after_eret", 5'd12, 32'h0000_0401);

        // Reserved instruction
        do_undef("ri_redirect", 32'h40);
        do_mfc("ri_epc", 5'd14, 32'h40);
        do_mfc("ri_cause", 5'd13, 32'h0000_0028);
        do_eret("ri_eret", 32'h40);

        // Address errors outrank undef and ignore stall
        do_mem("ades_redirect", 1'b1, 32'h20, 32'hFFFF_0000);
        do_mfc("ades_cause", 5'd13, 32'h0000_0014);
        do_mfc("ades_epc", 5'd14, 32'h20);
        do_mfc("ades_badvaddr", 5'd8, 32'hFFFF_0000);
        do_eret("ades_eret", 32'h20);
        do_mem("adel_redirect", 1'b0, 32'h24, 32'h0000_1234);
        do_mfc("adel_cause", 5'd13, 32'h0000_0010);
        do_eret("adel_eret", 32'h24);
        do_eret("eret_exl0", 32'h24);
        check("eret_exl0_exl", {32'h0, bus.exl}, 33'h0);

        // MTC0 Status discarded when an interrupt fires the same cycle
        pulse_ext0();
        push_redir("mtc_int_redirect", 32'h8, 1'b0);
        do_mtc(5'd12, 32'h0, 32'h200);
        do_mfc("mtc_int_status", 5'd12, 32'h0000_0403);
        do_mfc("mtc_int_epc", 5'd14, 32'h200);

        // Reset mid-handler
        rst = 1'b1;
        bus.cp0_addr = 5'd13;
        #1;
        check("rst_mid_exl", {32'h0, bus.exl}, 33'h0);
        check("rst_mid_cause", {1'b0, bus.rdata}, 33'h0);

        while (redir_q.size() > 0) begin
            mon_e = redir_q.pop_front();
            n_total++;
            $display("FAIL %s: actual=no redirect required=%h", mon_e.name, mon_e.val);
        end
        while (read_q.size() > 0) begin
            mon_e = read_q.pop_front();
            n_total++;
            $display("FAIL %s: actual=no read required=%h", mon_e.name, mon_e.val);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
